reg_file_scoreboard: RTL

- MIPS general-purpose register file: 2^ADDR_W registers, two combinational read ports and one write-back port.
- Register 0 is hard-wired to zero, with the same semantics as the standalone zero register.
- Adds a per-register busy scoreboard. Decode marks a destination busy at issue; write-back clears it.
- Asserts stall while a source or destination register has a pending write. Sits between decode (reads/issue) and write-back (writes).

---
 rtl/reg_file_scoreboard.sv | 104 ++++++++++
 1 files changed

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: general-purpose register file with a per-register
// busy scoreboard. Register 0 reads as zero and ignores writes. Decode marks
// a destination busy at issue; write-back clears it. stall flags a RAW/WAW
// hazard against any pending producer.
//
// Optional feature macro: RF_WRITE_BYPASS_EN
//   defined   - write-back data is forwarded to the read ports in the same
//               cycle, and the written register counts as no longer busy
//               for the hazard check in that cycle.
//   undefined - reads return the old value in the write-back cycle; a
//               dependent issue proceeds one cycle later.
module reg_file_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  localparam int NREGS = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic              issue_uses_b,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              stall,
  output logic [NREGS-1:0]  busy_vec
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;
  logic [NREGS-1:0]  busy_eff;
  logic              wr_hit;
  logic              hazard;

  assign wr_hit   = wr_en && (wr_addr != '0);
  assign busy_vec = busy_q;

`ifdef RF_WRITE_BYPASS_EN
  logic [NREGS-1:0] wr_onehot;

  // One-hot of the register being written back this cycle
  always_comb begin
    wr_onehot = '0;
    if (wr_en) wr_onehot[wr_addr] = 1'b1;
  end

  assign busy_eff = busy_q & ~wr_onehot;
`else
  assign busy_eff = busy_q;
`endif

  // Hazard detection against pending producers; stalled issues change nothing
  always_comb begin
    hazard = busy_eff[ra_addr]
           | (issue_uses_b & busy_eff[rb_addr])
           | busy_eff[issue_rd];
    stall  = issue_en & hazard;
  end

  // Combinational read ports; index 0 is forced to zero
  always_comb begin
    ra_data = regs_q[ra_addr];
    rb_data = regs_q[rb_addr];
`ifdef RF_WRITE_BYPASS_EN
    if (wr_hit && (wr_addr == ra_addr)) ra_data = wr_data;
    if (wr_hit && (wr_addr == rb_addr)) rb_data = wr_data;
`endif
    if (ra_addr == '0) ra_data = '0;
    if (rb_addr == '0) rb_data = '0;
  end

  // Next register contents: write-back to any index except 0
  always_comb begin
    regs_d = regs_q;
    if (wr_hit) regs_d[wr_addr] = wr_data;
    regs_d[0] = '0;
  end

  // Next busy bits: write-back clears, a successful issue sets (set wins)
  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[wr_addr] = 1'b0;
    if (issue_en && !stall && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // State registers; reset drops all data and pending writes immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

endmodule
